// File: rtl/hazard_stall_ctrl_pkg.sv
//==============================================================================
// Module : pipe_pkg
// Brief  : Shared pipeline constants and the Tuse/Tnew source-hazard helper.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

    typedef logic [4:0] reg_addr_t;
    typedef logic [1:0] timing_t;

    localparam timing_t   TUSE_NONE   = 2'd3;
    localparam reg_addr_t REG_ZERO    = 5'd0;
    localparam int        MULT_CYC_DEF = 5;
    localparam int        DIV_CYC_DEF  = 10;
    localparam int        CNT_W_DEF    = 4;

    // A source stalls when a live producer will not have its result ready by
    // the time this instruction needs it.
    function automatic logic src_hazard(
        input reg_addr_t src,
        input timing_t   tuse,
        input reg_addr_t a3_e,
        input timing_t   tnew_e,
        input reg_addr_t a3_m,
        input timing_t   tnew_m
    );
        return (src != REG_ZERO) && (tuse != TUSE_NONE) &&
               (((src == a3_e) && (tnew_e > tuse)) ||
                ((src == a3_m) && (tnew_m > tuse)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
//==============================================================================
// Module : hazard_stall_ctrl_if
// Brief  : Pipeline-side hazard information in, stall/flush controls out.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface hazard_stall_ctrl_if;
    import pipe_pkg::*;

    reg_addr_t   rs_D;
    reg_addr_t   rt_D;
    timing_t     tuse_rs_D;
    timing_t     tuse_rt_D;
    logic        md_use_D;
    reg_addr_t   a3_E;
    timing_t     tnew_E;
    reg_addr_t   a3_M;
    timing_t     tnew_M;
    logic        md_start_E;
    logic        md_is_div_E;

    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        output a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_is_div_E,
        input  StallF, StallD, FlushE, md_busy, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        input  a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_is_div_E,
        output StallF, StallD, FlushE, md_busy, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
//==============================================================================
// Module : md_busy_counter
// Brief  : Loadable down-counter tracking mult/div unit occupancy.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_start,
    input  wire logic i_is_div,
    output logic      o_busy
);

    // The start cycle is itself the first busy cycle, so the counter only
    // covers the remaining CYC-1 cycles.
    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_is_div ? c_div_load : c_mult_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = reset & ((r_cnt != '0) | i_start);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
//==============================================================================
// Module : hazard_stall_ctrl
// Brief  : Stall/flush controller for RAW and mult/div structural hazards.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_stall_ctrl_if.slave bus
);

    logic        w_stall_rs;
    logic        w_stall_rt;
    logic        w_md_busy;
    logic        w_md_stall;
    logic        w_stall;
    logic [31:0] r_stall_cnt;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .i_start  (bus.md_start_E),
        .i_is_div (bus.md_is_div_E),
        .o_busy   (w_md_busy)
    );

    assign w_stall_rs = src_hazard(bus.rs_D, bus.tuse_rs_D, bus.a3_E, bus.tnew_E,
                                   bus.a3_M, bus.tnew_M);
    assign w_stall_rt = src_hazard(bus.rt_D, bus.tuse_rt_D, bus.a3_E, bus.tnew_E,
                                   bus.a3_M, bus.tnew_M);
    assign w_md_stall = bus.md_use_D & w_md_busy;

    // Everything is held quiet while reset is low, regardless of inputs.
    assign w_stall    = reset & (w_stall_rs | w_stall_rt | w_md_stall);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.StallF    = w_stall;
    assign bus.StallD    = w_stall;
    assign bus.FlushE    = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; vectors are {StallF,StallD,FlushE,md_busy}.
`default_nettype none

module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    int          total;
    int          bad;
    logic [31:0] exp_scnt;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.rs_D        = 5'd0;
        bus.rt_D        = 5'd0;
        bus.tuse_rs_D   = 2'd3;
        bus.tuse_rt_D   = 2'd3;
        bus.md_use_D    = 1'b0;
        bus.a3_E        = 5'd0;
        bus.tnew_E      = 2'd0;
        bus.a3_M        = 5'd0;
        bus.tnew_M      = 2'd0;
        bus.md_start_E  = 1'b0;
        bus.md_is_div_E = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        bus.rs_D = 5'd5; bus.tuse_rs_D = 2'd1; bus.a3_E = 5'd5; bus.tnew_E = 2'd2;
        bus.md_start_E = 1'b1; bus.md_use_D = 1'b1;
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy});
        end
        @(negedge clk);
        total++;
        if (bus.stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_stall_cnt got=%h exp=0", bus.stall_cnt);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({bus.StallD, bus.md_busy, bus.stall_cnt} !== 34'd0) begin
            bad++;
            $display("FAIL reset_release got StallD=%b busy=%b cnt=%h exp 0/0/0",
                     bus.StallD, bus.md_busy, bus.stall_cnt);
        end
        exp_scnt = 32'd0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        bus.rs_D = 5'd5; bus.tuse_rs_D = 2'd1; bus.a3_E = 5'd5; bus.tnew_E = 2'd2;
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== 4'b1110) begin
            bad++;
            $display("FAIL load_use_stall got=%b exp=1110",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy});
        end
        exp_scnt++;
        @(negedge clk);
        bus.a3_E = 5'd0; bus.tnew_E = 2'd0; bus.a3_M = 5'd5; bus.tnew_M = 2'd1;
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== 4'b0000) begin
            bad++;
            $display("FAIL load_use_release got=%b exp=0000",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy});
        end
        total++;
        if (bus.stall_cnt !== 32'd1) begin
            bad++;
            $display("FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt);
        end
    endtask

    task automatic test_branch();
        logic [3:0] exp_v [0:4];
        exp_v[0] = 4'b1110; exp_v[1] = 4'b1110; exp_v[2] = 4'b0000;
        exp_v[3] = 4'b1110; exp_v[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_inputs();
            bus.rs_D = 5'd7; bus.tuse_rs_D = 2'd0;
            case (i)
                0: begin bus.a3_E = 5'd7; bus.tnew_E = 2'd2; end  // load in E
                1: begin bus.a3_M = 5'd7; bus.tnew_M = 2'd1; end  // load in M
                2: ;                                              // load in W
                3: begin bus.a3_E = 5'd7; bus.tnew_E = 2'd1; end  // ALU in E
                default: begin bus.a3_M = 5'd7; bus.tnew_M = 2'd0; end
            endcase
            #1;
            total++;
            if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== exp_v[i]) begin
                bad++;
                $display("FAIL branch_step%0d got=%b exp=%b", i,
                         {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy}, exp_v[i]);
            end
            if (exp_v[i][2]) exp_scnt++;
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.stall_cnt !== exp_scnt) begin
            bad++;
            $display("FAIL branch_cnt got=%0d exp=%0d", bus.stall_cnt, exp_scnt);
        end
    endtask

    task automatic test_zero_unused();
        logic [3:0] exp_v [0:4];
        exp_v[0] = 4'b0000; exp_v[1] = 4'b0000; exp_v[2] = 4'b1110;
        exp_v[3] = 4'b1110; exp_v[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_inputs();
            case (i)
                0: begin bus.rs_D = 5'd0; bus.tuse_rs_D = 2'd1; bus.a3_E = 5'd0; bus.tnew_E = 2'd2; end
                1: begin bus.rt_D = 5'd9; bus.tuse_rt_D = 2'd3; bus.a3_E = 5'd9; bus.tnew_E = 2'd2; end
                2: begin bus.rt_D = 5'd9; bus.tuse_rt_D = 2'd1; bus.a3_E = 5'd9; bus.tnew_E = 2'd2; end
                3: begin bus.rt_D = 5'd4; bus.tuse_rt_D = 2'd1; bus.a3_M = 5'd4; bus.tnew_M = 2'd2; end
                default: begin bus.rt_D = 5'd4; bus.tuse_rt_D = 2'd1; bus.a3_M = 5'd4; bus.tnew_M = 2'd1; end
            endcase
            #1;
            total++;
            if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== exp_v[i]) begin
                bad++;
                $display("FAIL zero_unused_case%0d got=%b exp=%b", i,
                         {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy}, exp_v[i]);
            end
            if (exp_v[i][2]) exp_scnt++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if (bus.stall_cnt !== exp_scnt) begin
            bad++;
            $display("FAIL zero_unused_cnt got=%0d exp=%0d", bus.stall_cnt, exp_scnt);
        end
    endtask

    task automatic test_md(input logic is_div, input int ncyc);
        @(negedge clk);
        clear_inputs();
        bus.md_start_E = 1'b1; bus.md_is_div_E = is_div; bus.md_use_D = 1'b1;
        for (int i = 0; i <= ncyc; i++) begin
            if (i > 0) begin
                @(negedge clk);
                bus.md_start_E = 1'b0;
            end
            #1;
            total++;
            if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !==
                ((i < ncyc) ? 4'b1111 : 4'b0000)) begin
                bad++;
                $display("FAIL md_div%0d_cycle%0d got=%b exp=%b", is_div, i,
                         {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy},
                         (i < ncyc) ? 4'b1111 : 4'b0000);
            end
            if (i < ncyc) exp_scnt++;
        end
        total++;
        if (bus.stall_cnt !== exp_scnt) begin
            bad++;
            $display("FAIL md_div%0d_cnt got=%0d exp=%0d", is_div, bus.stall_cnt, exp_scnt);
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        clear_inputs();
        bus.md_start_E = 1'b1; bus.md_use_D = 1'b1;
        bus.rs_D = 5'd5; bus.tuse_rs_D = 2'd1; bus.a3_E = 5'd5; bus.tnew_E = 2'd2;
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy} !== 4'b1111) begin
            bad++;
            $display("FAIL simul_both got=%b exp=1111",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy});
        end
        exp_scnt++;
        @(negedge clk);
        clear_inputs();
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.md_busy, bus.stall_cnt} !==
            {4'b0001, exp_scnt}) begin
            bad++;
            $display("FAIL simul_single_count got=%b cnt=%0d exp=0001 cnt=%0d",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.md_busy}, bus.stall_cnt, exp_scnt);
        end
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (bus.md_busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_busy_drain got=%b exp=0", bus.md_busy);
        end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        clear_inputs();
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1; bus.md_use_D = 1'b1;
        exp_scnt++;
        repeat (3) begin
            @(negedge clk);
            bus.md_start_E = 1'b0;
            exp_scnt++;
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.StallD, bus.md_busy, bus.stall_cnt} !== {2'b11, exp_scnt}) begin
            bad++;
            $display("FAIL mid_div_before got StallD=%b busy=%b cnt=%0d exp 1/1/%0d",
                     bus.StallD, bus.md_busy, bus.stall_cnt, exp_scnt);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.StallD, bus.md_busy, bus.stall_cnt} !== 34'd0) begin
            bad++;
            $display("FAIL mid_div_async got StallD=%b busy=%b cnt=%0d exp 0/0/0",
                     bus.StallD, bus.md_busy, bus.stall_cnt);
        end
        exp_scnt = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({bus.StallD, bus.md_busy, bus.stall_cnt} !== 34'd0) begin
            bad++;
            $display("FAIL mid_div_after got StallD=%b busy=%b cnt=%0d exp 0/0/0",
                     bus.StallD, bus.md_busy, bus.stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_inputs();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        #1;
        total++;
        if (bus.stall_cnt !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL sat_preload got=%h exp=fffffffe", bus.stall_cnt);
        end
        bus.rs_D = 5'd5; bus.tuse_rs_D = 2'd1; bus.a3_E = 5'd5; bus.tnew_E = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.stall_cnt !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL sat_cycle%0d got=%h exp=ffffffff", i, bus.stall_cnt);
            end
        end
        clear_inputs();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_scnt = 32'd0;
        test_reset();
        test_load_use();
        test_branch();
        test_zero_unused();
        test_md(1'b0, 5);
        test_md(1'b1, 10);
        test_simultaneous();
        test_reset_mid_div();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
